// File: rtl/fifo_pkg.sv
// Shared defaults and sizing rules for the FIFO controller slice.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 13;
  localparam int DEF_RAM_DEPTH  = 5000;

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Pointer register that counts 0..DEPTH-1 and wraps explicitly, so DEPTH need not be a power of two.
module fifo_wrap_ptr #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 5000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] ptr
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] ptr_r;

  // Pointer register: clear beats advance, last entry wraps to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      ptr_r <= {WIDTH{1'b0}};
    end else if (en) begin
      ptr_r <= (ptr_r == LAST) ? {WIDTH{1'b0}} : (ptr_r + ONE);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external dual-port RAM with asynchronous read.
// Optional sticky overflow/underflow outputs are enabled by defining FIFO_ERR_FLAGS_EN.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RAM_DEPTH  = DEF_RAM_DEPTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  output logic                                rd_valid,
  input  logic                                rd_ready,
  output logic [DATA_WIDTH-1:0]               rd_data,
  output logic [count_width(ADDR_WIDTH)-1:0]  count,
  output logic                                full,
  output logic                                empty,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                                overflow,
  output logic                                underflow,
`endif
  output logic [ADDR_WIDTH-1:0]               ram_wr_addr,
  output logic [DATA_WIDTH-1:0]               ram_wr_data,
  output logic                                ram_we,
  output logic [ADDR_WIDTH-1:0]               ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]               ram_rd_data
);

  localparam int CW = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(RAM_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_nxt_s;
  logic                  full_r;
  logic                  empty_r;
  logic                  push_s;
  logic                  pop_s;
  logic [ADDR_WIDTH-1:0] wr_ptr_s;
  logic [ADDR_WIDTH-1:0] rd_ptr_s;

  // Reset is folded in so the RAM never sees a write strobe while reset is held.
  assign wr_ready = ~full_r;
  assign rd_valid = ~empty_r;
  assign push_s   = wr_valid & ~full_r & ~flush & ~reset;
  assign pop_s    = rd_ready & ~empty_r & ~flush;

  fifo_wrap_ptr #(.WIDTH(ADDR_WIDTH), .DEPTH(RAM_DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .en    (push_s),
    .ptr   (wr_ptr_s)
  );

  fifo_wrap_ptr #(.WIDTH(ADDR_WIDTH), .DEPTH(RAM_DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .en    (pop_s),
    .ptr   (rd_ptr_s)
  );

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + ONE_C;
        2'b01:   count_nxt_s = count_r - ONE_C;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Occupancy and flags registered together so the flags always match count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == {CW{1'b0}});
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky misuse flags, cleared only by reset or flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r | (wr_valid & full_r);
      underflow_r <= underflow_r | (rd_ready & empty_r);
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`endif

  assign count       = count_r;
  assign full        = full_r;
  assign empty       = empty_r;
  assign ram_we      = push_s;
  assign ram_wr_addr = wr_ptr_s;
  assign ram_wr_data = wr_data;
  assign ram_rd_addr = rd_ptr_s;
  assign rd_data     = ram_rd_data;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl with a small behavioural RAM (depth 5, non-power-of-two).
module tb_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 5;
  localparam int CW    = AW + 1;

  logic          clk = 1'b0;
  logic          reset, flush, wr_valid, rd_ready;
  logic [DW-1:0] wr_data, rd_data, ram_wr_data, ram_rd_data;
  logic          wr_ready, rd_valid, full, empty, ram_we;
  logic [CW-1:0] count;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow, underflow;
`endif

  int checks = 0;
  int errors = 0;
  int m_count, m_wp, m_rp;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
  assign ram_rd_data = mem[ram_rd_addr];

  fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .full(full), .empty(empty),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow(overflow), .underflow(underflow),
`endif
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_we(ram_we),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  task automatic model_clear();
    m_count = 0; m_wp = 0; m_rp = 0;
    sb.delete();
  endtask

  // Drives one cycle from mid-cycle; pushes accepted words to the scoreboard, pops and compares heads.
  task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
    logic exp_push, exp_pop;
    logic [DW-1:0] exp_d;
    wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl;
    #1;
    exp_push = wv && (m_count != DEPTH) && !fl;
    exp_pop  = rr && (m_count != 0) && !fl;
    checks++; if (count !== CW'(m_count)) begin errors++; $display("FAIL count: got %0d exp %0d", count, m_count); end
    checks++; if (ram_we !== exp_push) begin errors++; $display("FAIL ram_we: got %b exp %b", ram_we, exp_push); end
    checks++; if (rd_valid !== (m_count != 0)) begin errors++; $display("FAIL rd_valid: got %b exp %b", rd_valid, m_count != 0); end
    if (exp_pop) begin
      exp_d = sb.pop_front();
      checks++; if (rd_data !== exp_d) begin errors++; $display("FAIL rd_data: got %h exp %h", rd_data, exp_d); end
    end
    if (exp_push) sb.push_back(wd);
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else begin
      if (exp_push) m_wp = (m_wp == DEPTH-1) ? 0 : m_wp + 1;
      if (exp_pop)  m_rp = (m_rp == DEPTH-1) ? 0 : m_rp + 1;
      m_count = m_count + int'(exp_push) - int'(exp_pop);
    end
    #1;
    wr_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = 8'h00;
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    wr_valid = 1'b1;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b exp 0", full); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", count); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready: got %b exp 1", wr_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %b exp 0", rd_valid); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we: got %b exp 0", ram_we); end
    wr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL idle_empty: got %b exp 1", empty); end
  endtask

  task automatic test_basic();
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL fwft_valid: got %b exp 1", rd_valid); end
    checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL fwft_data: got %h exp 11", rd_data); end
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL basic_count: got %0d exp 3", count); end
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty: got %b exp 1", empty); end
  endtask

  task automatic test_full_wrap();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b exp 1", full); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b exp 0", wr_ready); end
    checks++; if (ram_wr_addr !== 3'd0) begin errors++; $display("FAIL wp_wrap0: got %0d exp 0", ram_wr_addr); end
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL full_reject: got %0d exp 5", count); end
    repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'hB0, 1'b0, 1'b0);
    checks++; if (ram_wr_addr !== 3'd1) begin errors++; $display("FAIL wp_wrap1: got %0d exp 1", ram_wr_addr); end
    cycle(1'b1, 8'hB1, 1'b0, 1'b0);
    repeat (DEPTH) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_drain: got %b exp 1", empty); end
  endtask

  task automatic test_back_to_back();
    int rp0, wp0;
    cycle(1'b1, 8'hC0, 1'b0, 1'b0);
    cycle(1'b1, 8'hC1, 1'b0, 1'b0);
    rp0 = m_rp; wp0 = m_wp;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'hD0 + 8'(i), 1'b1, 1'b0);
      checks++; if (count !== 4'd2) begin errors++; $display("FAIL b2b_count: got %0d exp 2", count); end
    end
    checks++; if (ram_rd_addr !== AW'((rp0 + 10) % DEPTH)) begin errors++; $display("FAIL b2b_rp: got %0d exp %0d", ram_rd_addr, (rp0 + 10) % DEPTH); end
    checks++; if (ram_wr_addr !== AW'((wp0 + 10) % DEPTH)) begin errors++; $display("FAIL b2b_wp: got %0d exp %0d", ram_wr_addr, (wp0 + 10) % DEPTH); end
    repeat (2) cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    cycle(1'b1, 8'hE0, 1'b0, 1'b0);
    cycle(1'b1, 8'hE1, 1'b0, 1'b0);
    cycle(1'b1, 8'hE2, 1'b0, 1'b0);
    cycle(1'b1, 8'hEF, 1'b1, 1'b1);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b exp 1", empty); end
    checks++; if (ram_wr_addr !== 3'd0) begin errors++; $display("FAIL flush_wp: got %0d exp 0", ram_wr_addr); end
    checks++; if (ram_rd_addr !== 3'd0) begin errors++; $display("FAIL flush_rp: got %0d exp 0", ram_rd_addr); end
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

`ifdef FIFO_ERR_FLAGS_EN
  task automatic test_err_flags();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_init: got %b exp 0", underflow); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b exp 1", underflow); end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b exp 1", underflow); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b exp 0", underflow); end
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL of_init: got %b exp 0", overflow); end
    cycle(1'b1, 8'h7F, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL of_set: got %b exp 1", overflow); end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL of_clear: got %b exp 0", overflow); end
  endtask
`endif

  task automatic test_async_reset();
    cycle(1'b1, 8'h41, 1'b0, 1'b0);
    cycle(1'b1, 8'h42, 1'b0, 1'b0);
    #2;
    wr_valid = 1'b1; wr_data = 8'h43;
    reset = 1'b1;
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL arst_count: got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %b exp 1", empty); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL arst_rd_valid: got %b exp 0", rd_valid); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL arst_wr_ready: got %b exp 1", wr_ready); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL arst_ram_we: got %b exp 0", ram_we); end
    checks++; if (ram_wr_addr !== 3'd0) begin errors++; $display("FAIL arst_wp: got %0d exp 0", ram_wr_addr); end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    reset = 1'b0;
    model_clear();
    cycle(1'b1, 8'h66, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_recover: got %b exp 1", empty); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_wrap();
    test_back_to_back();
    test_flush();
`ifdef FIFO_ERR_FLAGS_EN
    test_err_flags();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
